// File: rtl/sqrt_arbiter.sv
// Purpose : two-requester arbiter in front of one shared integer-sqrt unit.
// Latency : ack 1 cycle after the req sample; done 7 cycles after it with the
//           team sqrt unit, or TIMEOUT cycles after it if the unit never goes busy.
// Backpressure: one operation at a time. Requests are sampled only in IDLE, so a
//           requester simply holds req high until it sees its ack.
//
// Ports:
//   clk_in, rst_in          clock, synchronous active-high reset
//   req0_in/req1_in         requests; a0_in/a1_in 8-bit operands
//   ack0_out/ack1_out       one-cycle grant pulse (operand captured)
//   done0_out/done1_out     one-cycle completion pulse; err_out marks a launch timeout
//   y0_out/y1_out           per-requester result, held until that requester's next done
//   busy_out                high while an operation is in flight
//   sq_start_out/sq_a_out   launch and operand to the sqrt unit
//   sq_busy_in/sq_y_in      sqrt unit status and result
//
// Build option: define SQRT_ARB_RR_EN for round-robin tie breaking; without it,
// requester 0 always wins a tie.

module sqrt_arbiter #(
  parameter int TIMEOUT = 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       req0_in,
  input  logic       req1_in,
  input  logic [7:0] a0_in,
  input  logic [7:0] a1_in,
  output logic       ack0_out,
  output logic       ack1_out,
  output logic       done0_out,
  output logic       done1_out,
  output logic [3:0] y0_out,
  output logic [3:0] y1_out,
  output logic       err_out,
  output logic       busy_out,
  output logic       sq_start_out,
  output logic [7:0] sq_a_out,
  input  logic       sq_busy_in,
  input  logic [3:0] sq_y_in
);

  // Counter only has to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] to_cnt;
  logic          grant_idx;   // requester owning the current operation
  logic          pick;        // requester that would be granted this cycle

`ifdef SQRT_ARB_RR_EN
  logic last_grant;

  // On a tie, favour whoever was not served last.
  always_comb begin
    pick = 1'b0;
    if (req0_in && req1_in) begin
      pick = ~last_grant;
    end else if (req1_in) begin
      pick = 1'b1;
    end
  end
`else
  // Fixed priority: requester 1 only wins when requester 0 is silent.
  always_comb begin
    pick = 1'b0;
    if (!req0_in && req1_in) begin
      pick = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      to_cnt       <= '0;
      grant_idx    <= 1'b0;
      ack0_out     <= 1'b0;
      ack1_out     <= 1'b0;
      done0_out    <= 1'b0;
      done1_out    <= 1'b0;
      err_out      <= 1'b0;
      busy_out     <= 1'b0;
      y0_out       <= '0;
      y1_out       <= '0;
      sq_start_out <= 1'b0;
      sq_a_out     <= '0;
`ifdef SQRT_ARB_RR_EN
      last_grant   <= 1'b1;  // so requester 0 wins the first tie
`endif
    end else begin
      // Pulses default low; only the owning requester's pulse is raised below.
      ack0_out  <= 1'b0;
      ack1_out  <= 1'b0;
      done0_out <= 1'b0;
      done1_out <= 1'b0;
      err_out   <= 1'b0;

      case (state)
        IDLE: begin
          if (req0_in || req1_in) begin
            grant_idx    <= pick;
            sq_a_out     <= pick ? a1_in : a0_in;
            sq_start_out <= 1'b1;
            ack0_out     <= ~pick;
            ack1_out     <= pick;
            to_cnt       <= '0;
            busy_out     <= 1'b1;
            state        <= WAIT_BUSY;
`ifdef SQRT_ARB_RR_EN
            last_grant   <= pick;
`endif
          end
        end

        WAIT_BUSY: begin
          if (sq_busy_in) begin
            sq_start_out <= 1'b0;
            state        <= WAIT_DONE;
          end else if (to_cnt == TO_LAST) begin
            // Unit never accepted the launch: finish with an error, y untouched.
            sq_start_out <= 1'b0;
            done0_out    <= ~grant_idx;
            done1_out    <= grant_idx;
            err_out      <= 1'b1;
            busy_out     <= 1'b0;
            state        <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        WAIT_DONE: begin
          if (!sq_busy_in) begin
            if (grant_idx) begin
              y1_out <= sq_y_in;
            end else begin
              y0_out <= sq_y_in;
            end
            done0_out <= ~grant_idx;
            done1_out <= grant_idx;
            busy_out  <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          sq_start_out <= 1'b0;
          busy_out     <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
